// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver (start, 8 data LSB first, optional
// parity, one stop bit).
//
// Ports:
//   clk         receiver oversampling clock
//   rst         synchronous, active-high reset
//   RX_IN       serial line, idle high, already synchronised to clk
//   Prescale    clk cycles per bit (values below 4 are treated as 4)
//   PAR_EN      1 = frame carries a parity bit
//   PAR_TYP     0 = even parity, 1 = odd parity
//   P_DATA      last correctly received byte
//   data_valid  one-cycle strobe, P_DATA updated with a good frame
//   par_err     one-cycle strobe, parity mismatch in the frame just ended
//   stp_err     one-cycle strobe, stop bit sampled 0
//
// Build option: define UART_RX_MAJORITY_VOTE_EN to decide each bit by a 2-of-3
// vote of the samples at S-1, S, S+1 (S = P/2) instead of the single sample at S.
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [7:0]            P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                state, state_nxt;
   logic [PRESCALE_W-1:0] p_q, p_clamp, half, edge_cnt;
   logic [2:0]            bit_cnt;
   logic [7:0]            shreg;
   logic                  par_en_q, par_typ_q;
   logic                  par_flag, stp_flag;
   logic                  done;         // frame ended last cycle; report it now
   logic                  bit_last, smp_hit, smp_val;
   logic                  cfg_load, shift_en, par_chk, stp_chk, frame_end;

   assign p_clamp  = (Prescale < PRESCALE_W'(4)) ? PRESCALE_W'(4) : Prescale;
   assign half     = p_q >> 1;
   assign bit_last = (edge_cnt == p_q - PRESCALE_W'(1));

`ifdef UART_RX_MAJORITY_VOTE_EN
   // Earlier two samples are stored; the third is the live input at S+1.
   logic s_m1, s_0;
   always_ff @(posedge clk) begin
      if (rst) begin
         s_m1 <= 1'b1;
         s_0  <= 1'b1;
      end else begin
         if (edge_cnt == half - PRESCALE_W'(1)) s_m1 <= RX_IN;
         if (edge_cnt == half)                  s_0  <= RX_IN;
      end
   end
   assign smp_hit = (edge_cnt == half + PRESCALE_W'(1));
   assign smp_val = (s_m1 & s_0) | (s_m1 & RX_IN) | (s_0 & RX_IN);
`else
   assign smp_hit = (edge_cnt == half);
   assign smp_val = RX_IN;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (!RX_IN) state_nxt = START;
         START: begin
            // A high start sample is a glitch; abandon without any strobe.
            if (smp_hit && smp_val) state_nxt = IDLE;
            else if (bit_last)      state_nxt = DATA;
         end
         DATA:   if (bit_last && bit_cnt == 3'd7) state_nxt = par_en_q ? PARITY : STOP;
         PARITY: if (bit_last) state_nxt = STOP;
         STOP:   if (bit_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath controls decoded from the state
   always_comb begin
      cfg_load  = (state == IDLE) && !RX_IN;
      shift_en  = (state == DATA)   && smp_hit;
      par_chk   = (state == PARITY) && smp_hit;
      stp_chk   = (state == STOP)   && smp_hit;
      frame_end = (state == STOP)   && bit_last;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q        <= '0;
         edge_cnt   <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         par_flag   <= 1'b0;
         stp_flag   <= 1'b0;
         done       <= 1'b0;
         P_DATA     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         // Strobe cycle: FSM is already in IDLE and may be loading a new frame,
         // so the flags read here are still those of the finished frame.
         if (done) begin
            if (!par_flag && !stp_flag) begin
               P_DATA     <= shreg;
               data_valid <= 1'b1;
            end else begin
               par_err <= par_flag;
               stp_err <= stp_flag;
            end
         end
         done <= frame_end;

         // The IDLE->START cycle counts as edge 0 of the start bit.
         if (cfg_load) begin
            edge_cnt  <= PRESCALE_W'(1);
            p_q       <= p_clamp;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            par_flag  <= 1'b0;
            stp_flag  <= 1'b0;
            bit_cnt   <= '0;
         end else if (state == IDLE || state_nxt == IDLE || bit_last) begin
            edge_cnt <= '0;
         end else begin
            edge_cnt <= edge_cnt + PRESCALE_W'(1);
         end

         if (state == DATA && bit_last) bit_cnt <= bit_cnt + 3'd1;
         if (shift_en) shreg[bit_cnt] <= smp_val;
         if (par_chk && (smp_val != ((^shreg) ^ par_typ_q))) par_flag <= 1'b1;
         if (stp_chk && !smp_val) stp_flag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       RX_IN;
   logic [5:0] Prescale;
   logic       PAR_EN, PAR_TYP;
   logic [7:0] P_DATA;
   logic       data_valid, par_err, stp_err;

   uart_rx #(.PRESCALE_W(6)) dut (
      .clk(clk), .rst(rst), .RX_IN(RX_IN), .Prescale(Prescale),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
      .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // strobe monitor, sampled away from the active edge
   int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, dv_cyc = 0;
   always @(negedge clk) begin
      if (data_valid) begin dv_cnt++; dv_cyc = cyc; end
      if (par_err) pe_cnt++;
      if (stp_err) se_cnt++;
   end

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Drives one frame cycle by cycle. flip_at inverts RX_IN for one cycle at
   // that frame offset; rst_at pulses reset at that offset and abandons the frame.
   // Config inputs are scrambled after the first cycle: they must be latched.
   task automatic send_frame(input logic [7:0] d, input logic [5:0] pres,
                             input logic pe, input logic pt, input logic pb,
                             input logic sb, input int flip_at, input int rst_at);
      int p, nb, b;
      logic v;
      p  = (pres < 4) ? 4 : int'(pres);
      nb = pe ? 11 : 10;
      Prescale = pres; PAR_EN = pe; PAR_TYP = pt;
      for (int c = 0; c < nb * p; c++) begin
         b = c / p;
         if (b == 0)                 v = 1'b0;
         else if (b <= 8)            v = d[b-1];
         else if (pe && b == 9)      v = pb;
         else                        v = sb;
         RX_IN = v ^ (c == flip_at);
         if (c == 1) begin Prescale = pres ^ 6'h2A; PAR_EN = ~pe; PAR_TYP = ~pt; end
         if (c == rst_at) begin
            rst = 1'b1;
            wait_cyc(1);
            chk("rst_mid_pdata", P_DATA, 0);
            chk("rst_mid_dv",    data_valid, 0);
            chk("rst_mid_pe",    par_err, 0);
            chk("rst_mid_se",    stp_err, 0);
            rst = 1'b0; RX_IN = 1'b1;
            return;
         end
         wait_cyc(1);
      end
      RX_IN = 1'b1;
   endtask

   typedef struct {
      logic [7:0] data;
      logic [5:0] pres;
      logic       par_en, par_typ, par_bit, stop_b;
      logic [7:0] exp_pd;
      int         exp_dv, exp_pe, exp_se;
   } vec_t;

   vec_t vt[8];

   initial begin
      int dv0, pe0, se0, t0;

      vt[0] = '{8'h3C, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1, 0, 0}; // even parity ok
      vt[1] = '{8'h3C, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 0, 1, 0}; // even parity bad
      vt[2] = '{8'h0F, 6'd8,  1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 0, 0, 1}; // stop bit 0
      vt[3] = '{8'h55, 6'd8,  1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1, 0, 0};
      vt[4] = '{8'h3C, 6'd16, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 0, 1, 1}; // both errors
      vt[5] = '{8'h96, 6'd16, 1'b1, 1'b1, 1'b1, 1'b1, 8'h96, 1, 0, 0}; // odd parity ok
      vt[6] = '{8'h5A, 6'd2,  1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1, 0, 0}; // clamps to 4
      vt[7] = '{8'hE7, 6'd13, 1'b0, 1'b0, 1'b0, 1'b1, 8'hE7, 1, 0, 0}; // odd P

      rst = 1'b1; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
      wait_cyc(3);
      chk("reset_pdata", P_DATA, 0);
      chk("reset_dv",    data_valid, 0);
      chk("reset_pe",    par_err, 0);
      chk("reset_se",    stp_err, 0);
      rst = 1'b0;
      wait_cyc(3);

      // basic frame with latency check
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt; t0 = cyc;
      send_frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
      wait_cyc(5);
      chk("a5_dv_count", dv_cnt - dv0, 1);
      chk("a5_latency",  dv_cyc - t0, 81);
      chk("a5_pdata",    P_DATA, 8'hA5);
      chk("a5_no_err",   (pe_cnt - pe0) + (se_cnt - se0), 0);

      foreach (vt[i]) begin
         dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
         send_frame(vt[i].data, vt[i].pres, vt[i].par_en, vt[i].par_typ,
                    vt[i].par_bit, vt[i].stop_b, -1, -1);
         wait_cyc(4);
         chk($sformatf("vec%0d_dv", i),    dv_cnt - dv0, vt[i].exp_dv);
         chk($sformatf("vec%0d_pe", i),    pe_cnt - pe0, vt[i].exp_pe);
         chk($sformatf("vec%0d_se", i),    se_cnt - se0, vt[i].exp_se);
         chk($sformatf("vec%0d_pdata", i), P_DATA, vt[i].exp_pd);
      end

      // bad stop bit followed immediately by a good frame
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      send_frame(8'h0F, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
      send_frame(8'h55, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
      wait_cyc(4);
      chk("b2b_se",    se_cnt - se0, 1);
      chk("b2b_dv",    dv_cnt - dv0, 1);
      chk("b2b_pe",    pe_cnt - pe0, 0);
      chk("b2b_pdata", P_DATA, 8'h55);

      // start-bit glitch: low for 2 clk only
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      Prescale = 6'd8; PAR_EN = 1'b0;
      RX_IN = 1'b0; wait_cyc(2);
      RX_IN = 1'b1; wait_cyc(20);
      chk("glitch_strobes", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
      send_frame(8'hC3, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
      wait_cyc(4);
      chk("glitch_next_dv",    dv_cnt - dv0, 1);
      chk("glitch_next_pdata", P_DATA, 8'hC3);

      // reset in the middle of data bit 4 (bit index 5)
      dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
      send_frame(8'hF5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 5 * 8 + 4);
      wait_cyc(100);
      chk("rst_mid_strobes", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
      send_frame(8'h81, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
      wait_cyc(4);
      chk("rst_next_dv",    dv_cnt - dv0, 1);
      chk("rst_next_pdata", P_DATA, 8'h81);

      // one-cycle flip at edge_cnt 8 of data bit 2 (frame offset 3*16+8)
      dv0 = dv_cnt;
      send_frame(8'h00, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 56, -1);
      wait_cyc(4);
      chk("flip_dv", dv_cnt - dv0, 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
      chk("flip_pdata", P_DATA, 8'h00);
`else
      chk("flip_pdata", P_DATA, 8'h04);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
